// File: rtl/draw_sequencer.sv
// Purpose: clears the screen pixel by pixel, then hands pixel output to a reuleaux draw engine.
// Latency: first clear pixel one cycle after start is seen in IDLE; SCREEN_W*SCREEN_H clear cycles precede DRAW.
// Backpressure: none; plots every CLEAR cycle unconditionally, DRAW is paced by the engine's eng_done.
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   start, colour, centre_x/y,
//   diameter                        request level and shape parameters (latched on IDLE->CLEAR)
//   done                            high only in DONE
//   eng_start, eng_colour,
//   eng_centre_x/y, eng_diameter    start and latched parameters to the draw engine
//   eng_done, eng_vga_*             engine completion and engine pixel stream
//   vga_x, vga_y, vga_colour,
//   vga_plot                        pixel write port to the VGA adapter
module draw_sequencer #(
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] diameter,
    output logic       done,
    output logic       eng_start,
    output logic [2:0] eng_colour,
    output logic [7:0] eng_centre_x,
    output logic [6:0] eng_centre_y,
    output logic [7:0] eng_diameter,
    input  logic       eng_done,
    input  logic [7:0] eng_vga_x,
    input  logic [6:0] eng_vga_y,
    input  logic [2:0] eng_vga_colour,
    input  logic       eng_vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    logic [1:0] state;
    logic [7:0] x_cnt;
    logic [6:0] y_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            x_cnt        <= 8'd0;
            y_cnt        <= 7'd0;
            eng_colour   <= 3'd0;
            eng_centre_x <= 8'd0;
            eng_centre_y <= 7'd0;
            eng_diameter <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        eng_colour   <= colour;
                        eng_centre_x <= centre_x;
                        eng_centre_y <= centre_y;
                        eng_diameter <= diameter;
                        x_cnt        <= 8'd0;
                        y_cnt        <= 7'd0;
                        state        <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    // Column-major walk: y runs fastest, x advances on each column wrap.
                    // Counters return to 0 after the last pixel rather than overrunning.
                    if (y_cnt == Y_LAST) begin
                        y_cnt <= 7'd0;
                        if (x_cnt == X_LAST) begin
                            x_cnt <= 8'd0;
                            state <= S_DRAW;
                        end else begin
                            x_cnt <= x_cnt + 8'd1;
                        end
                    end else begin
                        y_cnt <= y_cnt + 7'd1;
                    end
                end
                S_DRAW: begin
                    if (eng_done) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Leaving DONE needs start low, so a held start cannot re-trigger.
                    if (!start) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state; while rst_n is low they are forced quiet
    // so nothing is plotted in the cycle before reset takes effect.
    always_comb begin
        done       = 1'b0;
        eng_start  = 1'b0;
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;
        vga_plot   = 1'b0;
        if (rst_n) begin
            case (state)
                S_CLEAR: begin
                    vga_x      = x_cnt;
                    vga_y      = y_cnt;
                    vga_colour = CLEAR_COLOUR;
                    vga_plot   = 1'b1;
                end
                S_DRAW: begin
                    eng_start  = 1'b1;
                    vga_x      = eng_vga_x;
                    vga_y      = eng_vga_y;
                    vga_colour = eng_vga_colour;
                    vga_plot   = eng_vga_plot;
                end
                S_DONE: begin
                    done = 1'b1;
                end
                default: begin
                    done = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameter SCREEN_W, default 160, meaning: horizontal pixel count cleared.
REQ-002 Parameter SCREEN_H, default 120, meaning: vertical pixel count cleared.
REQ-003 Parameter CLEAR_COLOUR, default 3'b000, meaning: colour written during the clear phase.
REQ-004 Ports, in order:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  level request; held high until done is seen.
- colour  input  3  shape colour.
- centre_x  input  8  shape centre x.
- centre_y  input  7  shape centre y.
- diameter  input  8  shape diameter.
- done  output  1  sequence complete.
- eng_start  output  1  start to the downstream reuleaux engine.
- eng_colour  output  3  latched colour to the engine.
- eng_centre_x  output  8  latched centre_x to the engine.
- eng_centre_y  output  7  latched centre_y to the engine.
- eng_diameter  output  8  latched diameter to the engine.
- eng_done  input  1  engine done.
- eng_vga_x  input  8  engine pixel x.
- eng_vga_y  input  7  engine pixel y.
- eng_vga_colour  input  3  engine pixel colour.
- eng_vga_plot  input  1  engine pixel strobe.
- vga_x  output  8  pixel x to the VGA adapter.
- vga_y  output  7  pixel y to the VGA adapter.
- vga_colour  output  3  pixel colour to the VGA adapter.
- vga_plot  output  1  pixel write strobe.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, CLEAR, DRAW and DONE.
REQ-006 In IDLE with start=1, the FSM SHALL latch colour, centre_x, centre_y and diameter into the eng_* registers, reset x and y counters to 0, and enter CLEAR on the next edge.
REQ-007 In CLEAR, the outputs SHALL be vga_x=x counter, vga_y=y counter, vga_colour=CLEAR_COLOUR and vga_plot=1 on every cycle.
REQ-008 The clear order SHALL be y inner and x outer: y increments each cycle; at y=SCREEN_H-1, y wraps to 0 and x increments.
REQ-009 CLEAR SHALL emit exactly SCREEN_W*SCREEN_H plot cycles (19200 at default). The first pixel is (0,0) and the last is (159,119).
REQ-010 The cycle after the last clear pixel SHALL be DRAW, and the counters SHALL NOT overflow past SCREEN_W-1 or SCREEN_H-1.
REQ-011 In DRAW, eng_start SHALL be 1, and vga_x, vga_y, vga_colour and vga_plot SHALL combinationally equal the eng_vga_* inputs.
REQ-012 In DRAW with eng_done=1, the FSM SHALL enter DONE on the next edge.
REQ-013 In DONE, done SHALL be 1, eng_start SHALL be 0 and vga_plot SHALL be 0. The FSM SHALL remain in DONE while start=1 and return to IDLE on the first edge with start=0.
REQ-014 In IDLE and DONE, vga_plot SHALL be 0, and vga_x, vga_y and vga_colour SHALL be 0.
REQ-015 done SHALL be 0 in every state except DONE, and eng_start SHALL be 0 in every state except DRAW.
REQ-016 Changes on colour, centre_x, centre_y or diameter after the IDLE latch SHALL have no effect until the next IDLE->CLEAR transition.
REQ-017 If start drops during CLEAR or DRAW, the sequence SHALL still run to completion. DONE then lasts exactly one cycle (done=1), followed by IDLE.
REQ-018 eng_done and eng_vga_plot SHALL be ignored in IDLE, CLEAR and DONE.
REQ-019 A new sequence SHALL require start=0 observed in DONE and then start=1 in IDLE. Holding start high SHALL NOT restart the sequence.

Reset
REQ-020 On a clk edge with rst_n=0, the FSM SHALL enter IDLE, counters SHALL go to 0, and the eng_* parameter registers SHALL go to 0. This applies from any state, including mid-CLEAR and mid-DRAW.
REQ-021 While in or immediately after reset: done=0, eng_start=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.

Verification
REQ-022 Basic sequence: reset, then start=1 with colour=3'b010, centre=(80,60), diameter=40, eng_done forced 1 after 100 DRAW cycles. Required: exactly 19200 plots with colour 0, first (0,0), last (159,119); then eng_start=1 with eng_centre_x=80, eng_centre_y=60, eng_diameter=40; done=1 after 100 DRAW cycles.
REQ-023 Passthrough: in DRAW, drive eng_vga_x=5, eng_vga_y=7, eng_vga_colour=3'b010, eng_vga_plot=1. Required: the same values appear on vga_* in the same cycle.
REQ-024 Parameter stability: change centre_x to 100 mid-CLEAR. Required: eng_centre_x stays 80 through DONE.
REQ-025 Done handshake: start held high 5000 cycles past done -> done stays 1, vga_plot=0, no second clear; drop start -> IDLE next edge; raise start with centre=(50,50), diameter=50 -> new 19200-pixel clear.
REQ-026 Reset mid-CLEAR: rst_n=0 at clear pixel 1000 -> next edge vga_plot=0, done=0; restart begins at pixel (0,0).
REQ-027 Early start drop: drop start during DRAW -> done=1 for exactly one cycle after eng_done, then IDLE.
